shift_register: RTL and testbench



---
 rtl/regs_pkg.sv | 16 +
 rtl/dff_stage.sv | 46 ++++
 rtl/shift_register.sv | 60 ++++++
 tb/tb_shift_register.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// rtl/regs_pkg.sv - shared defaults and stage type for the register pipeline
//
// Purpose : default geometry of the generic delay line and the per-stage
//           word type used by the top and its flop stages.
// Ports   : none (package).
package regs_pkg;

    // Default geometry of the delay line.
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 5;

    // One pipeline stage word at the default width. Parameterised instances
    // declare their own logic [WIDTH-1:0] with the same shape.
    typedef logic [DEFAULT_WIDTH-1:0] stage_t;

endpackage

// File: rtl/dff_stage.sv
// rtl/dff_stage.sv - one WIDTH-bit pipeline flop with sync clear and enable
//
// Purpose : single storage stage of the delay line.
// Ports   : clk_i    rising-edge clock
//           reset_i  asynchronous active-low reset, clears the stage
//           en_i     load enable, 0 = hold
//           clr_i    synchronous clear, wins over en_i
//           d_i      stage input
//           q_o      stage output, driven straight from the flop
module dff_stage
    import regs_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Priority: clear, then load, else hold.
    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/shift_register.sv
// rtl/shift_register.sv - WIDTH x DEPTH register delay line with exported taps
//
// Purpose : generic delay primitive; q reproduces d delayed by DEPTH enabled
//           clock edges, and every stage is visible on taps.
// Ports   : clk    rising-edge clock
//           reset  asynchronous active-low reset, clears all stages
//           en     shift enable, 0 = all stages hold
//           clr    synchronous clear (active-high), wins over en
//           d      serial input into stage 0
//           q      stage DEPTH-1 (oldest sample)
//           taps   packed stages, taps[i*WIDTH +: WIDTH] = stage i
module shift_register
    import regs_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   clr,
    input  logic [WIDTH-1:0]       d,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH*DEPTH-1:0] taps
);

    if (DEPTH < 1) begin : g_depth_check
        $error("shift_register: DEPTH must be >= 1, got %0d", DEPTH);
    end

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Stage i loads from stage i-1; stage 0 loads from d. All stages share
    // en/clr so the whole line advances, holds or clears as one.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] stage_in;

        if (i == 0) begin : g_head
            assign stage_in = d;
        end else begin : g_link
            assign stage_in = stage_q[i-1];
        end

        dff_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk_i   (clk),
            .reset_i (reset),
            .en_i    (en),
            .clr_i   (clr),
            .d_i     (stage_in),
            .q_o     (stage_q[i])
        );

        assign taps[i*WIDTH +: WIDTH] = stage_q[i];
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: tb/tb_shift_register.sv
// tb/tb_shift_register.sv - self-checking bench for the register delay line
module tb_shift_register;

    typedef struct packed {
        logic [7:0]  q5;
        logic [39:0] taps5;
        logic [7:0]  q1;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        clr = 1'b0;
    logic [7:0]  d = 8'h01;
    logic [7:0]  q5;
    logic [39:0] taps5;
    logic [7:0]  q1;
    logic [7:0]  taps1;

    int vectors = 0;
    int errors  = 0;

    exp_t       sb[$];
    logic [7:0] m5 [5];
    logic [7:0] m1;

    always #5 clk = ~clk;

    shift_register #(.WIDTH(8), .DEPTH(5)) u_dut5 (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (clr),
        .d     (d),
        .q     (q5),
        .taps  (taps5)
    );

    shift_register #(.WIDTH(8), .DEPTH(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (clr),
        .d     (d),
        .q     (q1),
        .taps  (taps1)
    );

    task automatic model_zero();
        for (int i = 0; i < 5; i++) m5[i] = 8'h00;
        m1 = 8'h00;
    endtask

    // Waits for the next rising edge, advances the reference model with the
    // inputs present at that edge and queues the expected outputs.
    task automatic edge_push();
        exp_t e;
        @(posedge clk);
        if (!reset || clr) begin
            model_zero();
        end else if (en) begin
            for (int i = 4; i > 0; i--) m5[i] = m5[i-1];
            m5[0] = d;
            m1    = d;
        end
        e.q5    = m5[4];
        e.taps5 = {m5[4], m5[3], m5[2], m5[1], m5[0]};
        e.q1    = m1;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t       e;
        logic [7:0] first_d;
        logic [7:0] sampled;
        d = 8'h01; reset = 1'b1; en = 1'b1; clr = 1'b0;
        @(negedge clk); d = d + 8'd1;
        @(negedge clk); d = d + 8'd1;
        #3 reset = 1'b0;
        model_zero();
        #1;
        vectors++;
        if (q5 !== 8'h00 || taps5 !== 40'h0 || q1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: q5=%h taps5=%h q1=%h required all zero", q5, taps5, q1);
        end
        edge_push();
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (q5 !== e.q5 || taps5 !== e.taps5 || q1 !== e.q1) begin
            errors++;
            $display("FAIL reset_edge: q5=%h taps5=%h q1=%h required %h %h %h", q5, taps5, q1, e.q5, e.taps5, e.q1);
        end
        d = d + 8'd1;
        #3 reset = 1'b1;
        first_d = d;
        for (int k = 1; k <= 7; k++) begin
            edge_push();
            @(negedge clk);
            sampled = d;
            e = sb.pop_front();
            vectors++;
            if (q5 !== e.q5 || taps5 !== e.taps5 || q1 !== e.q1) begin
                errors++;
                $display("FAIL reset_model k=%0d: q5=%h taps5=%h q1=%h required %h %h %h", k, q5, taps5, q1, e.q5, e.taps5, e.q1);
            end
            vectors++;
            if (q5 !== ((k < 5) ? 8'h00 : first_d + 8'(k - 5))) begin
                errors++;
                $display("FAIL reset_fill k=%0d: q5=%h required %h", k, q5, (k < 5) ? 8'h00 : first_d + 8'(k - 5));
            end
            vectors++;
            if (q1 !== sampled) begin
                errors++;
                $display("FAIL depth1_dff k=%0d: q1=%h required %h", k, q1, sampled);
            end
            d = d + 8'd1;
        end
    endtask

    task automatic test_long_reset();
        exp_t       e;
        logic [7:0] first_d;
        #8 reset = 1'b0;
        model_zero();
        #1;
        vectors++;
        if (q5 !== 8'h00 || taps5 !== 40'h0 || q1 !== 8'h00) begin
            errors++;
            $display("FAIL long_reset_async: q5=%h taps5=%h q1=%h required all zero", q5, taps5, q1);
        end
        for (int k = 0; k < 7; k++) begin
            clr = (k == 2 || k == 3);
            en  = (k != 4);
            edge_push();
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (q5 !== 8'h00 || taps5 !== 40'h0 || q1 !== 8'h00 || e.taps5 !== 40'h0) begin
                errors++;
                $display("FAIL long_reset_hold k=%0d: q5=%h taps5=%h q1=%h required all zero", k, q5, taps5, q1);
            end
            d = d + 8'd1;
        end
        clr = 1'b0; en = 1'b1;
        #3 reset = 1'b1;
        first_d = d;
        for (int k = 1; k <= 5; k++) begin
            edge_push();
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (q5 !== e.q5 || taps5 !== e.taps5 || q1 !== e.q1) begin
                errors++;
                $display("FAIL refill_model k=%0d: q5=%h taps5=%h q1=%h required %h %h %h", k, q5, taps5, q1, e.q5, e.taps5, e.q1);
            end
            vectors++;
            if (q5 !== ((k < 5) ? 8'h00 : first_d)) begin
                errors++;
                $display("FAIL refill_q k=%0d: q5=%h required %h", k, q5, (k < 5) ? 8'h00 : first_d);
            end
            d = d + 8'd1;
        end
    endtask

    task automatic test_stream();
        exp_t       e;
        logic [7:0] prev_q;
        logic [7:0] exp_v;
        logic       saw_wrap;
        saw_wrap = 1'b0;
        prev_q   = q5;
        for (int k = 0; k < 260; k++) begin
            edge_push();
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (q5 !== e.q5 || taps5 !== e.taps5 || q1 !== e.q1 || taps1 !== e.q1) begin
                errors++;
                $display("FAIL stream_model k=%0d: q5=%h taps5=%h q1=%h required %h %h %h", k, q5, taps5, q1, e.q5, e.taps5, e.q1);
            end
            if (prev_q === 8'hFF && q5 === 8'h00) saw_wrap = 1'b1;
            prev_q = q5;
            d = d + 8'd1;
            exp_v = d - 8'd1;
            vectors++;
            if (taps5[7:0] !== exp_v) begin
                errors++;
                $display("FAIL stream_tap0 k=%0d: tap0=%h required %h", k, taps5[7:0], exp_v);
            end
            exp_v = d - 8'd5;
            vectors++;
            if (q5 !== exp_v) begin
                errors++;
                $display("FAIL stream_q k=%0d: q5=%h required %h", k, q5, exp_v);
            end
        end
        vectors++;
        if (saw_wrap !== 1'b1) begin
            errors++;
            $display("FAIL stream_wrap: wrap seen=%b required 1", saw_wrap);
        end
    endtask

    task automatic test_enable();
        exp_t        e;
        logic [39:0] snap;
        logic [7:0]  snap1;
        logic [7:0]  prev_q;
        en    = 1'b0;
        snap  = taps5;
        snap1 = q1;
        for (int k = 0; k < 3; k++) begin
            edge_push();
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (q5 !== e.q5 || taps5 !== e.taps5 || q1 !== e.q1) begin
                errors++;
                $display("FAIL hold_model k=%0d: q5=%h taps5=%h q1=%h required %h %h %h", k, q5, taps5, q1, e.q5, e.taps5, e.q1);
            end
            vectors++;
            if (taps5 !== snap || q1 !== snap1) begin
                errors++;
                $display("FAIL hold_frozen k=%0d: taps5=%h q1=%h required %h %h", k, taps5, q1, snap, snap1);
            end
            d = d + 8'd1;
        end
        en     = 1'b1;
        prev_q = q5;
        for (int k = 0; k < 4; k++) begin
            edge_push();
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (q5 !== e.q5 || taps5 !== e.taps5 || q1 !== e.q1) begin
                errors++;
                $display("FAIL resume_model k=%0d: q5=%h taps5=%h q1=%h required %h %h %h", k, q5, taps5, q1, e.q5, e.taps5, e.q1);
            end
            vectors++;
            if (q5 !== prev_q + 8'd1) begin
                errors++;
                $display("FAIL resume_seq k=%0d: q5=%h required %h", k, q5, prev_q + 8'd1);
            end
            prev_q = q5;
            d = d + 8'd1;
        end
    endtask

    task automatic test_clear();
        exp_t e;
        d = 8'h7F; clr = 1'b1; en = 1'b1;
        edge_push();
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (taps5 !== 40'h0 || q1 !== 8'h00 || e.taps5 !== taps5) begin
            errors++;
            $display("FAIL clr_zero: taps5=%h q1=%h required all zero", taps5, q1);
        end
        clr = 1'b0; d = 8'h80;
        edge_push();
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (taps5 !== e.taps5 || q1 !== e.q1) begin
            errors++;
            $display("FAIL clr_next_model: taps5=%h q1=%h required %h %h", taps5, q1, e.taps5, e.q1);
        end
        vectors++;
        if (taps5[15:0] !== 16'h0080 || q1 !== 8'h80) begin
            errors++;
            $display("FAIL clr_no_capture: taps5[15:0]=%h q1=%h required 0080 80", taps5[15:0], q1);
        end
        d = 8'h81; clr = 1'b1;
        #2 reset = 1'b0;
        model_zero();
        #1;
        vectors++;
        if (q5 !== 8'h00 || taps5 !== 40'h0 || q1 !== 8'h00) begin
            errors++;
            $display("FAIL clr_and_reset_async: q5=%h taps5=%h q1=%h required all zero", q5, taps5, q1);
        end
        edge_push();
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (q5 !== e.q5 || taps5 !== e.taps5 || q1 !== e.q1) begin
            errors++;
            $display("FAIL clr_and_reset_edge: q5=%h taps5=%h q1=%h required %h %h %h", q5, taps5, q1, e.q5, e.taps5, e.q1);
        end
        clr = 1'b0; reset = 1'b1; d = 8'h90;
        for (int k = 0; k < 2; k++) begin
            edge_push();
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (q5 !== e.q5 || taps5 !== e.taps5 || q1 !== e.q1) begin
                errors++;
                $display("FAIL post_clr_model k=%0d: q5=%h taps5=%h q1=%h required %h %h %h", k, q5, taps5, q1, e.q5, e.taps5, e.q1);
            end
            d = d + 8'd1;
        end
    endtask

    initial begin
        test_reset();
        test_long_reset();
        test_stream();
        test_enable();
        test_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
